crossy_robbers_soc_leds_blink_pio: RTL and testbench
====================================================

Name: crossy_robbers_soc_leds_blink_pio

Overview:
- Parametrised Avalon-MM output PIO for the board LEDs. Successor to the fixed 14-bit LED PIO.
- Adds generic width, atomic set/clear registers, per-channel hardware blinking from a programmable prescaler, and optional global PWM dimming.
- Sits on the Nios II data master in the SoC. out_port drives the LED pins directly.

Parameters:
- WIDTH, 14, number of LED channels (1..32).
- PRESCALE_W, 24, width of the blink prescaler counter and the PERIOD register.
- RESET_VALUE, 0, reset value of the DATA register (bits above WIDTH are ignored).
- DEFAULT_PERIOD, 2500000, reset value of PERIOD (about 50 ms half-period at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; zero wait states, read latency 0.
- out_port  out  WIDTH  LED drive.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset; it is sampled only on the rising edge of clk.
- A write occurs when chipselect=1 and write_n=0; the target register updates at that clk edge. Unused writedata bits are ignored.
- Register map (address):
  - 0 DATA: read/write.
  - 1 BLINK_MASK: read/write.
  - 2 PERIOD: read/write, PRESCALE_W bits. A write also clears the prescaler and phase.
  - 3 STATUS: read-only. bit0=phase, bits[PRESCALE_W:1] hold nothing and read 0.
  - 4 OUTSET: write-only. DATA <= DATA | wd.
  - 5 OUTCLEAR: write-only. DATA <= DATA & ~wd.
  - 6, 7: reserved. Reads return 0; writes are ignored.
- readdata is combinational from address. Unused high bits are zero. Addresses 4 and 5 read 0.
- Reset values: DATA=RESET_VALUE[WIDTH-1:0], BLINK_MASK=0, PERIOD=DEFAULT_PERIOD, prescaler=0, phase=0, out_port=RESET_VALUE[WIDTH-1:0].
- Prescaler, when PERIOD != 0:
  - Counter increments every cycle.
  - When counter == PERIOD-1: counter <= 0 and phase toggles.
  - Full blink cycle = 2*PERIOD clocks.
- PERIOD == 0: counter and phase are held at 0, so blinking channels stay steadily on.
- PERIOD written to a value below the current count: the write clears the counter, so no wrap-around stall can occur.
- out_port = DATA & ~(BLINK_MASK & {WIDTH{phase}}). It is a combinational function of registers, so it has no glitch sources beyond register outputs.
- Latency: a register write at edge N is visible on out_port and readdata from edge N onward, i.e. within the same clock period that follows edge N.
- Reset asserted mid-blink: all state returns to reset values at the next edge. Reset has priority over a simultaneous write.
- The prescaler runs regardless of bus activity. A PERIOD write on the same edge as a terminal count takes precedence: counter=0 and phase=0.

Optional Feature:
- Macro: CROSSY_LEDS_PWM_EN.
- Defined:
  - Address 6 becomes DUTY, 8-bit read/write, reset value 8'hFF.
  - A free-running 8-bit pwm_cnt (reset 0) increments every clk and wraps 255->0.
  - out_port = blink result & {WIDTH{(pwm_cnt < DUTY) | (DUTY == 8'hFF)}}.
  - DUTY=0 gives fully off; DUTY=255 gives fully on.
- Undefined: address 6 is reserved (reads 0), no pwm_cnt logic exists, and out_port is the blink result.

Test Plan:
- Reset held 2 cycles with RESET_VALUE=14'h0005 -> out_port=0x0005, readdata at address 0 = 0x00000005, at address 1 = 0, at address 2 = 2500000.
- Write DATA=0x0F0F, then OUTSET 0x3000, then OUTCLEAR 0x000F -> DATA reads 0x3F00 and out_port=0x3F00; reads of addresses 4/5/7 return 0.
- PERIOD=4, BLINK_MASK=0x0003, DATA=0x0007 -> out_port alternates 0x0007 for 4 clocks and 0x0004 for 4 clocks; STATUS bit0 tracks the phase.
- PERIOD=0 written while phase=1 -> phase reads 0 on the next cycle and out_port is steady at DATA with no toggling for 100 cycles.
- Reset asserted in the same cycle as a write DATA=0x1234 during blinking -> DATA=RESET_VALUE, BLINK_MASK=0, phase=0, and the write is discarded.
- With CROSSY_LEDS_PWM_EN, DUTY=64, BLINK_MASK=0, DATA=0x3FFF -> out_port=0x3FFF for exactly 64 of every 256 clocks; DUTY=0 -> out_port=0 constantly.

Source files
------------

// File: rtl/crossy_robbers_soc_leds_blink_pio.sv
// Avalon-MM LED output PIO with atomic set/clear, per-channel blinking and optional PWM dimming.
// Optional global dimming (DUTY register at address 6) is built when CROSSY_LEDS_PWM_EN is defined.
module crossy_robbers_soc_leds_blink_pio #(
    parameter int          WIDTH          = 14,
    parameter int          PRESCALE_W     = 24,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd2500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [PRESCALE_W-1:0] PS_ONE = 1;

    logic                  wr_en;
    logic [WIDTH-1:0]      data_reg, data_next;
    logic [WIDTH-1:0]      mask_reg, mask_next;
    logic [PRESCALE_W-1:0] period_reg, period_next;
    logic [PRESCALE_W-1:0] count_reg, count_next;
    logic                  phase_reg, phase_next;
    logic                  pwm_on;
    logic [WIDTH-1:0]      blink_bits;
    logic                  unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign unused_writedata = ^writedata;

    always_comb begin
        data_next   = data_reg;
        mask_next   = mask_reg;
        period_next = period_reg;
        count_next  = count_reg;
        phase_next  = phase_reg;

        if (period_reg == '0) begin
            count_next = '0;
            phase_next = 1'b0;
        end else if (count_reg == period_reg - PS_ONE) begin
            count_next = '0;
            phase_next = ~phase_reg;
        end else begin
            count_next = count_reg + PS_ONE;
        end

        // A PERIOD write restarts the blink cycle and beats a coincident terminal count.
        if (wr_en) begin
            case (address)
                3'd0: data_next = writedata[WIDTH-1:0];
                3'd1: mask_next = writedata[WIDTH-1:0];
                3'd2: begin
                    period_next = writedata[PRESCALE_W-1:0];
                    count_next  = '0;
                    phase_next  = 1'b0;
                end
                3'd4: data_next = data_reg | writedata[WIDTH-1:0];
                3'd5: data_next = data_reg & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= RESET_VALUE[WIDTH-1:0];
            mask_reg   <= '0;
            period_reg <= DEFAULT_PERIOD[PRESCALE_W-1:0];
            count_reg  <= '0;
            phase_reg  <= 1'b0;
        end else begin
            data_reg   <= data_next;
            mask_reg   <= mask_next;
            period_reg <= period_next;
            count_reg  <= count_next;
            phase_reg  <= phase_next;
        end
    end

`ifdef CROSSY_LEDS_PWM_EN
    logic [7:0] duty_reg, duty_next;
    logic [7:0] pwm_cnt_reg, pwm_cnt_next;

    always_comb begin
        duty_next    = duty_reg;
        pwm_cnt_next = pwm_cnt_reg + 8'd1;
        if (wr_en && address == 3'd6)
            duty_next = writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_reg    <= 8'hFF;
            pwm_cnt_reg <= 8'd0;
        end else begin
            duty_reg    <= duty_next;
            pwm_cnt_reg <= pwm_cnt_next;
        end
    end

    // DUTY=FF must be fully on even though pwm_cnt reaches 255.
    assign pwm_on = (pwm_cnt_reg < duty_reg) | (duty_reg == 8'hFF);
`else
    assign pwm_on = 1'b1;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[WIDTH-1:0]      = data_reg;
            3'd1: readdata[WIDTH-1:0]      = mask_reg;
            3'd2: readdata[PRESCALE_W-1:0] = period_reg;
            3'd3: readdata[0]              = phase_reg;
`ifdef CROSSY_LEDS_PWM_EN
            3'd6: readdata[7:0]            = duty_reg;
`endif
            default: readdata = '0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign blink_bits[gi] = data_reg[gi] & ~(mask_reg[gi] & phase_reg);
            assign out_port[gi]   = blink_bits[gi] & pwm_on;
        end
    endgenerate

endmodule

// File: tb/tb_crossy_robbers_soc_leds_blink_pio.sv
// Bench for the LED blink PIO: time-based reference model checked every cycle plus directed literals.
module tb_crossy_robbers_soc_leds_blink_pio;

    localparam int W = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    crossy_robbers_soc_leds_blink_pio #(
        .WIDTH(W), .PRESCALE_W(24), .RESET_VALUE(32'h5), .DEFAULT_PERIOD(32'd2500000)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    // Model: phase is derived from elapsed cycles since the last restart, not from a counter.
    logic [W-1:0]  m_data, m_mask;
    logic [23:0]   m_period;
    int unsigned   m_t;
    logic [7:0]    m_duty, m_pwm;

    always @(posedge clk) begin
        if (reset) begin
            m_data <= 14'h5; m_mask <= '0; m_period <= 24'd2500000;
            m_t <= 0; m_duty <= 8'hFF; m_pwm <= 8'd0;
        end else begin
            m_t   <= m_t + 1;
            m_pwm <= m_pwm + 8'd1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data <= writedata[W-1:0];
                    3'd1: m_mask <= writedata[W-1:0];
                    3'd2: begin m_period <= writedata[23:0]; m_t <= 0; end
                    3'd4: m_data <= m_data | writedata[W-1:0];
                    3'd5: m_data <= m_data & ~writedata[W-1:0];
`ifdef CROSSY_LEDS_PWM_EN
                    3'd6: m_duty <= writedata[7:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    function automatic logic m_phase();
        if (m_period == 0) return 1'b0;
        return ((m_t / m_period) % 2) == 1;
    endfunction

    function automatic logic [31:0] exp_out();
        logic [W-1:0] v;
        v = m_data & ~(m_mask & {W{m_phase()}});
`ifdef CROSSY_LEDS_PWM_EN
        if (!((m_pwm < m_duty) || (m_duty == 8'hFF))) v = '0;
`endif
        return {18'd0, v};
    endfunction

    function automatic logic [31:0] exp_rd();
        case (address)
            3'd0: return {18'd0, m_data};
            3'd1: return {18'd0, m_mask};
            3'd2: return {8'd0, m_period};
            3'd3: return {31'd0, m_phase()};
`ifdef CROSSY_LEDS_PWM_EN
            3'd6: return {24'd0, m_duty};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out_port", {18'd0, out_port}, exp_out());
            check("model_readdata", readdata, exp_rd());
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        @(negedge clk);
        check(name, readdata, exp);
    endtask

    initial begin
        int   cnt;
        bit   found;
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        @(negedge clk);
        check("reset_out_port", {18'd0, out_port}, 32'h5);
        read_check("reset_data", 3'd0, 32'h5);
        read_check("reset_mask", 3'd1, 32'h0);
        read_check("reset_period", 3'd2, 32'd2500000);
        read_check("reset_status", 3'd3, 32'h0);

        bus_write(3'd0, 32'hFFFF_0F0F);
        bus_write(3'd4, 32'h0000_3000);
        bus_write(3'd5, 32'h0000_000F);
        read_check("setclr_data", 3'd0, 32'h3F00);
        check("setclr_out_port", {18'd0, out_port}, 32'h3F00);
        read_check("read_addr4", 3'd4, 32'h0);
        read_check("read_addr5", 3'd5, 32'h0);
        read_check("read_addr6", 3'd6,
`ifdef CROSSY_LEDS_PWM_EN
                   32'hFF);
`else
                   32'h0);
`endif
        read_check("read_addr7", 3'd7, 32'h0);

        bus_write(3'd0, 32'h7);
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'd4);
        address = 3'd3;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("blink_out_port", {18'd0, out_port}, ((i / 4) % 2) ? 32'h4 : 32'h7);
            check("blink_status", readdata, ((i / 4) % 2) ? 32'h1 : 32'h0);
        end

        // Land a PERIOD=0 write on an edge where phase is 1.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (readdata[0]) found = 1'b1;
        end
        check("phase_wait", {31'd0, found}, 32'h1);
        #1;
        address = 3'd2; writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        read_check("period0_phase", 3'd3, 32'h0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_port !== 14'h7) cnt++;
        end
        check("period0_steady", cnt, 0);

        bus_write(3'd2, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; address = 3'd0; writedata = 32'h1234; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        check("rstwr_out_port", {18'd0, out_port}, 32'h5);
        read_check("rstwr_data", 3'd0, 32'h5);
        read_check("rstwr_mask", 3'd1, 32'h0);
        read_check("rstwr_status", 3'd3, 32'h0);

`ifdef CROSSY_LEDS_PWM_EN
        bus_write(3'd0, 32'h3FFF);
        bus_write(3'd6, 32'd64);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out_port === 14'h3FFF) cnt++;
        end
        check("pwm64_on_cycles", cnt, 64);
        bus_write(3'd6, 32'd0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out_port !== 14'h0) cnt++;
        end
        check("pwm0_on_cycles", cnt, 0);
`endif

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
